// File: rtl/approx_adder_pkg.sv
// rtl/approx_adder_pkg.sv - shared mode encoding and group sizing for the approximate CLA adder
package approx_adder_pkg;

   typedef enum logic {
      MODE_EXACT  = 1'b0,
      MODE_APPROX = 1'b1
   } approx_mode_e;

   function automatic int group_count(input int width, input int block);
      return (width + block - 1) / block;
   endfunction

endpackage

// File: rtl/cla_group.sv
// rtl/cla_group.sv - one carry-lookahead group: internal carries plus group generate/propagate
module cla_group #(
   parameter int BLOCK = 4
) (
   input  logic [BLOCK-1:0] g_i,
   input  logic [BLOCK-1:0] p_i,
   input  logic             c_i,
   output logic             g_o,
   output logic             p_o,
   output logic [BLOCK-1:0] c_o
);

   // Carry into position n as a flat sum of products over g/p and the group carry-in.
   function automatic logic lookahead(input logic [BLOCK-1:0] g, input logic [BLOCK-1:0] p,
                                      input logic cin, input int n);
      logic carry;
      logic term;
      carry = cin;
      for (int k = 0; k < n; k++) carry = carry & p[k];
      for (int j = 0; j < n; j++) begin
         term = g[j];
         for (int k = j + 1; k < n; k++) term = term & p[k];
         carry = carry | term;
      end
      return carry;
   endfunction

   always_comb begin
      c_o = '0;
      for (int i = 0; i < BLOCK; i++) c_o[i] = lookahead(g_i, p_i, c_i, i);
      g_o = lookahead(g_i, p_i, 1'b0, BLOCK);
      p_o = &p_i;
   end

endmodule

// File: rtl/pipelined_approx_cla_adder.sv
// rtl/pipelined_approx_cla_adder.sv - two-stage adder with approximate low bits, exact carries and error counter
module pipelined_approx_cla_adder
   import approx_adder_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int LOWER_WIDTH = 4,
   parameter int BLOCK       = 4,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [WIDTH-1:0]     add1_i,
   input  logic [WIDTH-1:0]     add2_i,
   input  logic                 approx_en_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   output logic [WIDTH:0]       result_o,
   output logic                 err_o,
   output logic                 valid_o,
   input  logic                 ready_i,
   input  logic                 clear_i,
   output logic [CNT_WIDTH-1:0] err_count_o
);

   localparam int NG = group_count(WIDTH, BLOCK);
   localparam int PW = NG * BLOCK;

   logic                 s1_valid_q;
   logic [WIDTH-1:0]     s1_a_q;
   logic [WIDTH-1:0]     s1_b_q;
   approx_mode_e         s1_mode_q;
   logic [PW-1:0]        s1_g_q;
   logic [PW-1:0]        s1_p_q;
   logic                 s2_valid_q;
   logic [WIDTH:0]       result_q;
   logic                 err_q;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic [CNT_WIDTH-1:0] cnt_d;

   logic                 s1_adv;
   logic                 s2_adv;
   logic [PW-1:0]        g_d;
   logic [PW-1:0]        p_d;
   logic [NG:0]          gc;
   logic [NG-1:0]        grp_g;
   logic [NG-1:0]        grp_p;
   logic [PW:0]          carry;
   logic [WIDTH-1:0]     sum_d;
   logic [WIDTH:0]       result_d;
   logic [WIDTH:0]       exact_d;
   logic                 err_d;

   assign s2_adv  = ~s2_valid_q | ready_i;
   assign s1_adv  = ~s1_valid_q | s2_adv;
   assign ready_o = s1_adv;

   // Padding bits beyond WIDTH carry g=p=0 so they never generate or propagate.
   always_comb begin
      g_d = '0;
      p_d = '0;
      g_d[WIDTH-1:0] = add1_i & add2_i;
      p_d[WIDTH-1:0] = add1_i | add2_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_mode_q  <= MODE_EXACT;
         s1_g_q     <= '0;
         s1_p_q     <= '0;
      end else if (s1_adv) begin
         s1_valid_q <= valid_i;
         if (valid_i) begin
            s1_a_q    <= add1_i;
            s1_b_q    <= add2_i;
            s1_mode_q <= approx_en_i ? MODE_APPROX : MODE_EXACT;
            s1_g_q    <= g_d;
            s1_p_q    <= p_d;
         end
      end
   end

   assign gc[0] = 1'b0;

   for (genvar k = 0; k < NG; k++) begin : g_grp
      cla_group #(.BLOCK(BLOCK)) u_grp (
         .g_i (s1_g_q[k*BLOCK +: BLOCK]),
         .p_i (s1_p_q[k*BLOCK +: BLOCK]),
         .c_i (gc[k]),
         .g_o (grp_g[k]),
         .p_o (grp_p[k]),
         .c_o (carry[k*BLOCK +: BLOCK])
      );
      assign gc[k+1] = grp_g[k] | (grp_p[k] & gc[k]);
   end

   assign carry[PW] = gc[NG];

   always_comb begin
      sum_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (s1_mode_q == MODE_APPROX && i < LOWER_WIDTH)
            sum_d[i] = ~(s1_a_q[i] ^ s1_b_q[i]);
         else
            sum_d[i] = s1_a_q[i] ^ s1_b_q[i] ^ carry[i];
      end
      result_d = {carry[WIDTH], sum_d};
      exact_d  = {1'b0, s1_a_q} + {1'b0, s1_b_q};
      err_d    = (result_d != exact_d);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s2_valid_q <= 1'b0;
         result_q   <= '0;
         err_q      <= 1'b0;
      end else if (s2_adv) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            result_q <= result_d;
            err_q    <= err_d;
         end
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)
         cnt_d = '0;
      else if (s2_valid_q && ready_i && err_q && !(&cnt_q))
         cnt_d = cnt_q + CNT_WIDTH'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign result_o    = result_q;
   assign err_o       = err_q;
   assign valid_o     = s2_valid_q;
   assign err_count_o = cnt_q;

endmodule

// File: tb/tb_pipelined_approx_cla_adder.sv
// tb/tb_pipelined_approx_cla_adder.sv - randomized scoreboard bench for the approximate CLA adder
module tb_pipelined_approx_cla_adder;

   localparam int W   = 16;
   localparam int LW  = 4;
   localparam int CW  = 4;
   localparam int MAX = 15;

   typedef struct {
      logic [W:0] res;
      logic       err;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  add1;
   logic [W-1:0]  add2;
   logic          approx_en;
   logic          valid_i;
   logic          ready_o;
   logic [W:0]    result_o;
   logic          err_o;
   logic          valid_o;
   logic          ready_i;
   logic          clear_i;
   logic [CW-1:0] err_count_o;

   int   checks = 0;
   int   errors = 0;
   int   model_cnt = 0;
   int   delivered = 0;
   exp_t exp_q[$];
   exp_t pending;
   logic last_acc, last_vo, last_ro;

   always #5 clk = ~clk;

   pipelined_approx_cla_adder #(.WIDTH(W), .LOWER_WIDTH(LW), .BLOCK(4), .CNT_WIDTH(CW)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .add1_i      (add1),
      .add2_i      (add2),
      .approx_en_i (approx_en),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .result_o    (result_o),
      .err_o       (err_o),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .clear_i     (clear_i),
      .err_count_o (err_count_o)
   );

   // Upper bits and carry-out are the true sum; the low LW bits are XNOR of the operands.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ap);
      exp_t       e;
      logic [W:0] exact, mask, xn;
      exact = {1'b0, a} + {1'b0, b};
      mask  = (W+1)'((1 << LW) - 1);
      xn    = {1'b0, ~(a ^ b)};
      e.res = ap ? ((exact & ~mask) | (xn & mask)) : exact;
      e.err = (e.res != exact);
      return e;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, expv, $time);
      end
   endtask

   task automatic step();
      logic fire, ferr;
      exp_t e;
      fire = 1'b0;
      ferr = 1'b0;
      @(negedge clk);
      last_acc = valid_i && ready_o;
      last_vo  = valid_o;
      last_ro  = ready_o;
      if (last_acc) exp_q.push_back(pending);
      if (valid_o && ready_i) begin
         fire = 1'b1;
         if (exp_q.size() == 0) begin
            check("unexpected_result", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("result", result_o, e.res);
            check("err", err_o, e.err);
            ferr = e.err;
            delivered++;
         end
      end
      if (clear_i) model_cnt = 0;
      else if (fire && ferr && model_cnt < MAX) model_cnt++;
      @(posedge clk);
      #1;
      check("err_count", err_count_o, model_cnt);
   endtask

   task automatic present(input logic [W-1:0] a, input logic [W-1:0] b, input logic ap);
      add1 = a; add2 = b; approx_en = ap;
      pending = model(a, b, ap);
      valid_i = 1'b1;
   endtask

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ap);
      int n;
      present(a, b, ap);
      n = 0;
      do begin
         step();
         n++;
      end while (!last_acc && n < 50);
      if (!last_acc) check("accept_timeout", 0, 1);
   endtask

   task automatic send_const(input logic [W-1:0] a, input logic [W-1:0] b, input logic ap,
                             input logic [W:0] res, input logic err);
      add1 = a; add2 = b; approx_en = ap;
      pending.res = res;
      pending.err = err;
      valid_i = 1'b1;
      step();
      if (!last_acc) check("const_accept", 0, 1);
   endtask

   task automatic drain();
      int n;
      valid_i = 1'b0;
      n = 0;
      while ((exp_q.size() != 0 || valid_o) && n < 50) begin
         step();
         n++;
      end
      if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
   endtask

   initial begin
      logic [W:0] held;
      int idx, n, d0;
      logic [W-1:0] pa[4];
      logic [W-1:0] pb[4];

      rst = 1'b1; add1 = '0; add2 = '0; approx_en = 1'b0;
      valid_i = 1'b0; ready_i = 1'b1; clear_i = 1'b0;
      #1;
      check("rst_valid_o", valid_o, 0);
      check("rst_ready_o", ready_o, 1);
      check("rst_result", result_o, 0);
      check("rst_err", err_o, 0);
      check("rst_count", err_count_o, 0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;

      // Directed corner values with hand-derived results.
      send_const(16'h0003, 16'h0005, 1'b1, 17'h00009, 1'b1);
      send_const(16'h0003, 16'h0005, 1'b0, 17'h00008, 1'b0);
      send_const(16'hFFFF, 16'h0001, 1'b1, 17'h10001, 1'b1);
      send_const(16'hFFFF, 16'h0001, 1'b0, 17'h10000, 1'b0);
      drain();
      check("directed_delivered", delivered, 4);

      // Backpressure: only two fit while the sink stalls.
      for (int i = 0; i < 4; i++) begin
         pa[i] = W'($urandom); pb[i] = W'($urandom);
      end
      ready_i = 1'b0;
      idx = 0;
      d0 = delivered;
      for (int c = 0; c < 4; c++) begin
         present(pa[idx], pb[idx], 1'b1);
         step();
         check("bp_ready_o", last_ro, (c < 2) ? 1 : 0);
         if (c == 2) held = result_o;
         if (c == 3) begin
            check("bp_hold_valid", valid_o, 1);
            check("bp_hold_result", result_o, held);
         end
         if (last_acc) idx++;
      end
      check("bp_accepted", idx, 2);
      ready_i = 1'b1;
      n = 0;
      while (idx < 4 && n < 20) begin
         present(pa[idx], pb[idx], 1'b1);
         step();
         if (last_acc) idx++;
         n++;
      end
      drain();
      check("bp_delivered", delivered - d0, 4);

      // Full-rate streaming.
      for (int i = 0; i < 100; i++) begin
         send(W'($urandom), W'($urandom), 1'($urandom));
         check("tp_ready_o", last_ro, 1);
         if (i >= 2) check("tp_valid_o", last_vo, 1);
      end
      drain();

      // Counter saturation and clear priority.
      clear_i = 1'b1; step(); clear_i = 1'b0;
      for (int i = 0; i < 20; i++) send(16'h0003, 16'h0005, 1'b1);
      drain();
      check("sat_count", err_count_o, MAX);
      send(16'h0003, 16'h0005, 1'b1);
      valid_i = 1'b0;
      step();
      check("clr_valid_ready", valid_o, 1);
      clear_i = 1'b1; step(); clear_i = 1'b0;
      check("clr_priority", err_count_o, 0);

      // Reset with two transactions in flight.
      send(16'h0003, 16'h0005, 1'b1);
      send(16'h0003, 16'h0005, 1'b1);
      drain();
      check("pre_rst_count", err_count_o, 2);
      send(16'h0003, 16'h0005, 1'b1);
      send(16'h0007, 16'h0001, 1'b1);
      valid_i = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_valid_o", valid_o, 0);
      check("mid_rst_count", err_count_o, 0);
      check("mid_rst_ready_o", ready_o, 1);
      exp_q.delete();
      model_cnt = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("post_rst_idle", last_vo, 0);
      end
      send(16'h1234, 16'h4321, 1'b0);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/pipelined_approx_cla_adder.md
PIPELINED_APPROX_CLA_ADDER -- requirements
Module: pipelined_approx_cla_adder

Interface
REQ-001 SHALL provide parameter WIDTH, default 16: operand width in bits, legal range 4 to 64.
REQ-002 SHALL provide parameter LOWER_WIDTH, default 4: number of approximate low-order sum bits, legal range 0 to WIDTH.
REQ-003 SHALL provide parameter BLOCK, default 4: lookahead group size, legal values 2, 4 or 8; WIDTH need not be a multiple of BLOCK.
REQ-004 SHALL provide parameter CNT_WIDTH, default 16: width of the error counter.
REQ-005 SHALL have port clk_i, input, 1 bit: single clock, all state on its rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port add1_i, input, WIDTH bits: operand A.
REQ-008 SHALL have port add2_i, input, WIDTH bits: operand B.
REQ-009 SHALL have port approx_en_i, input, 1 bit: 1 = approximate mode, 0 = exact mode; sampled per transaction.
REQ-010 SHALL have port valid_i, input, 1 bit: operands valid.
REQ-011 SHALL have port ready_o, output, 1 bit: block accepts operands.
REQ-012 SHALL have port result_o, output, WIDTH+1 bits: {carry-out, sum}.
REQ-013 SHALL have port err_o, output, 1 bit: result_o differs from the exact sum.
REQ-014 SHALL have port valid_o, output, 1 bit: result valid.
REQ-015 SHALL have port ready_i, input, 1 bit: downstream accepts the result.
REQ-016 SHALL have port clear_i, input, 1 bit: synchronous clear of the error counter.
REQ-017 SHALL have port err_count_o, output, CNT_WIDTH bits: saturating count of erroneous delivered results.

Function
REQ-018 SHALL compute carries exactly for all bits: g=a&b, p=a|b, group-lookahead per BLOCK, ripple between groups, carry-in 0.
REQ-019 SHALL produce sum bit i, for i<LOWER_WIDTH with approx_en=1, as XNOR(a[i],b[i]), ignoring carry-in; all other bits SHALL be a^b^c.
REQ-020 SHALL produce result_o[WIDTH] as the exact carry-out in both modes.
REQ-021 SHALL accept input on the cycle valid_i=1 and ready_o=1; operands and approx_en_i are captured together.
REQ-022 SHALL use two register stages: S1 holds operands, mode and per-group g/p; S2 holds result, err and exact-compare outcome. Latency is 2 cycles from accept to valid_o with no stall.
REQ-023 SHALL advance S2 when ~s2_valid | ready_i, and S1 when ~s1_valid | S2 advances; ready_o = ~s1_valid | S2 advances (combinational from ready_i).
REQ-024 SHALL sustain one transaction per cycle with ready_i held at 1.
REQ-025 SHALL keep result_o, err_o and valid_o stable while valid_o=1 and ready_i=0; SHALL never drop, duplicate or reorder transactions.
REQ-026 SHALL compute err_o by comparing result_o to the exact (WIDTH+1)-bit sum; err_o is always 0 in exact mode or when LOWER_WIDTH=0.
REQ-027 SHALL increment err_count_o by 1 on each cycle with valid_o & ready_i & err_o, saturating at all-ones.
REQ-028 SHALL give clear_i priority over a simultaneous increment; the counter is 0 on the next cycle.

Reset
REQ-029 SHALL, when rst_i is asserted, asynchronously force s1_valid, valid_o, err_o, err_count_o and result_o to 0; ready_o SHALL then read 1.
REQ-030 SHALL discard in-flight transactions on reset mid-operation; the first accept after rst_i is released starts a clean pipeline.

Structure
REQ-031 SHALL place the approximate-cell mode encoding and the group-count function ceil(WIDTH/BLOCK) in shared package approx_adder_pkg.
REQ-032 SHALL implement one lookahead group as sub-module cla_group (BLOCK-wide g/p in, group G/P and internal carries out), instantiated per group.

Verification
REQ-033 SHALL verify with WIDTH=16, LOWER_WIDTH=4, approx: 0x0003+0x0005 -> result 0x00009, err_o=1; exact mode -> 0x00008, err_o=0.
REQ-034 SHALL verify with approx: 0xFFFF+0x0001 -> result 0x10001, err_o=1; exact -> 0x10000, err_o=0.
REQ-035 SHALL verify backpressure: 4 back-to-back accepts with ready_i=0 -> 2 held, ready_o=0 from the 3rd cycle; ready_i=1 -> all 4 results in order, none lost.
REQ-036 SHALL verify throughput: 100 random transactions with ready_i=1 -> valid_o every cycle after 2-cycle latency; results match the reference model.
REQ-037 SHALL verify CNT_WIDTH=4: 20 erroneous transfers -> err_count_o saturates at 15; clear_i together with an erroneous transfer -> 0.
REQ-038 SHALL verify rst_i pulse with 2 transactions in flight -> valid_o=0 and err_count_o=0 immediately; no stale result appears after release.
